// File: rtl/afe_cfg_pkg.sv
// Shared types and constants for the AFE init sequencer: FSM states, SPI frame geometry
// and the init-table entry layout.
package afe_cfg_pkg;

  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned READ_BIT       = 7;
  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned IDX_W          = 6;
  localparam int unsigned BIT_CNT_W      = $clog2(SPI_FRAME_BITS);

  typedef enum logic [2:0] {
    RST_PULSE,
    RST_WAIT,
    LOAD,
    SHIFT,
    GAP,
    ENABLE,
    READY
  } afe_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cfg_entry_t;

  // Largest of three values, used to size the shared phase counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/afe_cfg_rom.sv
// Combinational AFE init table: maps an entry index to the {addr, data} pair written
// during the power-up sequence. Unlisted indices return an all-zero entry.
module afe_cfg_rom
  import afe_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = '0;
    case (idx)
      IDX_W'(0): entry = '{addr: 8'h00, data: 8'h01};
      IDX_W'(1): entry = '{addr: 8'h01, data: 8'h3C};
      IDX_W'(2): entry = '{addr: 8'h02, data: 8'hA0};
      IDX_W'(3): entry = '{addr: 8'h05, data: 8'h17};
      IDX_W'(4): entry = '{addr: 8'h0A, data: 8'hC3};
      IDX_W'(5): entry = '{addr: 8'h10, data: 8'h55};
      IDX_W'(6): entry = '{addr: 8'h21, data: 8'h0F};
      IDX_W'(7): entry = '{addr: 8'h3F, data: 8'h80};
      default:   entry = '0;
    endcase
  end

endmodule

// File: rtl/afe_init_seq.sv
// AFE power-up sequencer: reset pulse, settle wait, SPI init table, path enable, then host
// SPI access. Define AFE_READBACK_EN to capture MISO data of read frames into rd_data.
module afe_init_seq
  import afe_cfg_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned RST_CYCLES  = 64,
  parameter int unsigned WAIT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              afe_reset,
  output logic              afe_sen,
  output logic              afe_spi_clk,
  output logic              afe_spi_mosi,
  input  logic              afe_spi_miso,
  output logic              afe_tx_en,
  output logic              afe_rx_en
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, WAIT_CYCLES, CLK_DIV);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  afe_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      phase_q, phase_d;
  logic [BIT_CNT_W-1:0]      bit_q, bit_d;
  logic [SPI_FRAME_BITS-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      host_q, host_d;
  logic                      en_q, en_d;
  logic                      wr_ack_q, wr_ack_d;
  logic [DATA_W-1:0]         rd_data_q, rd_data_d;
  logic                      afe_reset_q, afe_reset_d;
  logic                      sen_q, sen_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  cfg_entry_t                rom_entry;

  afe_cfg_rom u_rom (
    .idx   (idx_q),
    .entry (rom_entry)
  );

  // Next-state logic; pin values are derived from the next state so they line up with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    host_d  = host_q;
    en_d    = en_q;

    if (restart) begin
      state_d = RST_PULSE;
      cnt_d   = '0;
      phase_d = 1'b0;
      bit_d   = '0;
      idx_d   = '0;
      host_d  = 1'b0;
      en_d    = 1'b0;
    end else begin
      case (state_q)
        RST_PULSE: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = RST_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        RST_WAIT: begin
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            state_d = (NUM_REGS == 0) ? ENABLE : LOAD;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOAD: begin
          state_d = SHIFT;
          sr_d    = rom_entry;
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          host_d  = 1'b0;
        end
        SHIFT: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_d = '0;
            if (!phase_q) begin
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (bit_q == BIT_CNT_W'(SPI_FRAME_BITS - 1)) begin
                state_d = GAP;
              end else begin
                bit_d = bit_q + BIT_CNT_W'(1);
                sr_d  = {sr_q[SPI_FRAME_BITS-2:0], 1'b0};
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cnt_d = '0;
            if (host_q) begin
              state_d = READY;
            end else if (idx_q == IDX_W'(NUM_REGS - 1)) begin
              state_d = ENABLE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = LOAD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ENABLE: state_d = READY;
        READY: begin
          if (wr_req) begin
            state_d = SHIFT;
            sr_d    = {wr_addr, wr_data};
            cnt_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
            host_d  = 1'b1;
          end
        end
        default: state_d = RST_PULSE;
      endcase
    end

    if (state_d == ENABLE) en_d = 1'b1;

    afe_reset_d = (state_d == RST_PULSE);
    sen_d       = (state_d != SHIFT);
    sclk_d      = (state_d == SHIFT) && phase_d;
    mosi_d      = (state_d == SHIFT) && sr_d[SPI_FRAME_BITS-1];
    done_d      = (state_d == READY);
    busy_d      = !done_d;
    wr_ack_d    = (state_d == GAP) && host_d && (cnt_d == CNT_W'(CLK_DIV - 1));
  end

`ifdef AFE_READBACK_EN
  logic              rd_frame_q, rd_frame_d;
  logic [DATA_W-1:0] rx_q, rx_d;

  // Data-phase MISO bits are taken on each SPI clock rise and published with the ack.
  always_comb begin
    rd_frame_d = rd_frame_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    if (!restart && (state_q == READY) && wr_req) begin
      rd_frame_d = wr_addr[READ_BIT];
      rx_d       = '0;
    end
    if (!restart && (state_q == SHIFT) && !phase_q && (cnt_q == CNT_W'(CLK_DIV - 1)) &&
        bit_q[BIT_CNT_W-1]) begin
      rx_d = {rx_q[DATA_W-2:0], afe_spi_miso};
    end
    if (wr_ack_d && rd_frame_q) rd_data_d = rx_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_frame_q <= 1'b0;
      rx_q       <= '0;
    end else begin
      rd_frame_q <= rd_frame_d;
      rx_q       <= rx_d;
    end
  end
`else
  logic unused_miso;
  assign unused_miso = afe_spi_miso;

  always_comb begin
    rd_data_d = '0;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RST_PULSE;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      bit_q       <= '0;
      sr_q        <= '0;
      idx_q       <= '0;
      host_q      <= 1'b0;
      en_q        <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      afe_reset_q <= 1'b1;
      sen_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      host_q      <= host_d;
      en_q        <= en_d;
      wr_ack_q    <= wr_ack_d;
      rd_data_q   <= rd_data_d;
      afe_reset_q <= afe_reset_d;
      sen_q       <= sen_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_ack       = wr_ack_q;
  assign rd_data      = rd_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign afe_reset    = afe_reset_q;
  assign afe_sen      = sen_q;
  assign afe_spi_clk  = sclk_q;
  assign afe_spi_mosi = mosi_q;
  assign afe_tx_en    = en_q;
  assign afe_rx_en    = en_q;

endmodule

// File: tb/tb_afe_init_seq.sv
// Bench for afe_init_seq: an SPI slave model captures frames and answers reads, and a
// transaction-level model predicts frames, ack latency and readback data.
module tb_afe_init_seq;

  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned NUM_REGS    = 3;
  localparam int unsigned RST_CYCLES  = 4;
  localparam int unsigned WAIT_CYCLES = 8;
  localparam int          FRAME_CLKS  = 32 * CLK_DIV;
  localparam int          ACK_LAT     = FRAME_CLKS + CLK_DIV;

  logic       clk, reset_n, restart, wr_req, miso;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ack, busy, done, afe_reset, afe_sen, afe_spi_clk, afe_spi_mosi;
  logic       afe_tx_en, afe_rx_en;
  logic [7:0] rd_data;

  logic       tie0;
  logic [7:0] tie8;
  logic       wr_ack0, busy0, done0, rst0, sen0, sclk0, mosi0, tx0, rx0;
  logic [7:0] rd_data0;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] rom_exp [3] = '{16'h0001, 16'h013C, 16'h02A0};
  logic [7:0]  rb_byte = 8'h00;
  logic [7:0]  rd_model = 8'h00;

  logic [15:0] fr_q [$];
  int          nb_q [$];
  int          len_q [$];
  int          sclk_viol = 0, mosi_viol = 0, idle_viol = 0, dut0_viol = 0;

  afe_init_seq #(
    .CLK_DIV(CLK_DIV), .NUM_REGS(NUM_REGS), .RST_CYCLES(RST_CYCLES), .WAIT_CYCLES(WAIT_CYCLES)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .restart(restart), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data), .busy(busy), .done(done),
    .afe_reset(afe_reset), .afe_sen(afe_sen), .afe_spi_clk(afe_spi_clk),
    .afe_spi_mosi(afe_spi_mosi), .afe_spi_miso(miso), .afe_tx_en(afe_tx_en),
    .afe_rx_en(afe_rx_en)
  );

  afe_init_seq #(
    .CLK_DIV(CLK_DIV), .NUM_REGS(0), .RST_CYCLES(RST_CYCLES), .WAIT_CYCLES(WAIT_CYCLES)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .restart(tie0), .wr_req(tie0), .wr_addr(tie8),
    .wr_data(tie8), .wr_ack(wr_ack0), .rd_data(rd_data0), .busy(busy0), .done(done0),
    .afe_reset(rst0), .afe_sen(sen0), .afe_spi_clk(sclk0), .afe_spi_mosi(mosi0),
    .afe_spi_miso(tie0), .afe_tx_en(tx0), .afe_rx_en(rx0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPI slave model: samples the pins shortly after each clk edge.
  logic [15:0] mon_bits = '0;
  int mon_nb = 0, mon_len = 0, fall_cnt = 0, hi_run = 0, lo_run = 0;
  bit prev_sen = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0;

  always @(posedge clk) begin
    #2;
    if (!afe_sen) begin
      mon_len++;
      if (afe_spi_clk && !prev_sclk) begin
        mon_bits = {mon_bits[14:0], afe_spi_mosi};
        mon_nb++;
        if (lo_run != CLK_DIV) sclk_viol++;
        hi_run = 0;
      end
      if (!afe_spi_clk && prev_sclk) begin
        fall_cnt++;
        if (hi_run != CLK_DIV) sclk_viol++;
        lo_run = 0;
      end
      if (afe_spi_clk) hi_run++;
      else lo_run++;
      if (afe_spi_clk && prev_sclk && (afe_spi_mosi !== prev_mosi)) mosi_viol++;
    end else begin
      if (!prev_sen) begin
        fr_q.push_back(mon_bits);
        nb_q.push_back(mon_nb);
        len_q.push_back(mon_len);
      end
      mon_bits = '0; mon_nb = 0; mon_len = 0; fall_cnt = 0; hi_run = 0; lo_run = 0;
      if (afe_spi_clk || afe_spi_mosi) idle_viol++;
    end
    miso = (!afe_sen && fall_cnt >= 8 && fall_cnt < 16) ? rb_byte[15-fall_cnt] : 1'b0;
    prev_sen  = afe_sen;
    prev_sclk = afe_spi_clk;
    prev_mosi = afe_spi_mosi;
    if (!sen0 || sclk0 || mosi0) dut0_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] exp, input int exp_nb);
    chk({tag, " queued"}, 32'(fr_q.size() != 0), 32'd1);
    if (fr_q.size() != 0) begin
      chk({tag, " data"}, 32'(fr_q[0]), 32'(exp));
      chk({tag, " bits"}, nb_q[0], exp_nb);
      if (exp_nb == 16) chk({tag, " len"}, len_q[0], FRAME_CLKS);
      void'(fr_q.pop_front());
      void'(nb_q.pop_front());
      void'(len_q.pop_front());
    end
  endtask

  task automatic chk_rom_frames(input string tag);
    for (int j = 0; j < int'(NUM_REGS); j++) chk_frame($sformatf("%s rom%0d", tag, j), rom_exp[j], 16);
  endtask

  // Waits for READY; no ack may appear while the init sequence runs.
  task automatic wait_done(input string tag);
    int n = 0, acks = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
      if (wr_ack) acks++;
    end
    chk({tag, " done reached"}, 32'(done), 32'd1);
    chk({tag, " no early ack"}, acks, 0);
    chk({tag, " enables"}, {afe_tx_en, afe_rx_en}, 2'b11);
  endtask

  // Called at a sample where the DUT is READY with wr_req high.
  task automatic wait_ack(input string tag);
    int lat = 0;
    bit got = 1'b0;
    while (!got && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) chk({tag, " frame start"}, {afe_sen, busy, done}, 3'b010);
      if (wr_ack) got = 1'b1;
    end
    chk({tag, " ack latency"}, lat, ACK_LAT);
    wr_req = 1'b0;
    @(negedge clk);
    chk({tag, " ack single"}, {wr_ack, done}, 2'b01);
  endtask

  task automatic host_check(input string tag, input logic [7:0] a, input logic [7:0] d,
                            input logic [7:0] rb);
`ifdef AFE_READBACK_EN
    if (a[7]) rd_model = rb;
`else
    rd_model = 8'h00;
    if (rb == 8'h00 && a == 8'h00 && d == 8'h00) rd_model = 8'h00;
`endif
    chk_frame({tag, " frame"}, {a, d}, 16);
    chk({tag, " rd_data"}, rd_data, rd_model);
  endtask

  task automatic host_xfer(input string tag, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rb);
    rb_byte = rb;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    wait_ack(tag);
    host_check(tag, a, d, rb);
  endtask

  initial begin
    logic [7:0] a, d, rb;
    int n_rst, n0_rst, n0_wait, n0_en, n0_first_done, n;

    reset_n = 1'b0; restart = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    tie0 = 1'b0; tie8 = '0; miso = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset afe_reset", afe_reset, 1'b1);
    chk("reset afe_sen", afe_sen, 1'b1);
    chk("reset spi pins", {afe_spi_clk, afe_spi_mosi}, 2'b00);
    chk("reset enables", {afe_tx_en, afe_rx_en}, 2'b00);
    chk("reset busy/done", {busy, done}, 2'b10);
    chk("reset wr_ack", wr_ack, 1'b0);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset dut0 pins", {rst0, sen0, done0, tx0}, 4'b1100);

    // Release; sample from the release edge onward.
    reset_n = 1'b1;
    n_rst = 0; n0_rst = 0; n0_wait = 0; n0_en = 0; n0_first_done = -1;
    for (int i = 0; i < 20; i++) begin
      if (afe_reset) n_rst++;
      if (rst0) n0_rst++;
      if (!rst0 && !tx0) n0_wait++;
      if (tx0 && !done0) n0_en++;
      if (done0 && n0_first_done < 0) n0_first_done = i;
      @(negedge clk);
    end
    chk("afe_reset pulse length", n_rst, RST_CYCLES);
    chk("regs0 reset pulse", n0_rst, RST_CYCLES);
    chk("regs0 wait length", n0_wait, WAIT_CYCLES);
    chk("regs0 enable length", n0_en, 1);
    chk("regs0 done time", n0_first_done, RST_CYCLES + WAIT_CYCLES + 1);

    // Request held from inside the second init frame.
    n = 0;
    while (fr_q.size() < 1 && n < 500) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    a = 8'($urandom); d = 8'($urandom); rb = 8'($urandom);
    rb_byte = rb; wr_addr = a; wr_data = d; wr_req = 1'b1;
    chk("pending during init", {wr_ack, done}, 2'b00);
    wait_done("init");
    chk_rom_frames("init");
    wait_ack("pending req");
    host_check("pending req", a, d, rb);

    host_xfer("write 12A5", 8'h12, 8'hA5, 8'($urandom));
    repeat (2) @(negedge clk);
    host_xfer("read 83", 8'h83, 8'h00, 8'h5C);

    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      host_xfer($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // Restart during bit 7 of a host frame; request stays asserted.
    a = 8'($urandom); d = 8'($urandom);
    rb_byte = 8'($urandom); wr_addr = a; wr_data = d; wr_req = 1'b1;
    repeat (30) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart abort pins", {afe_sen, afe_reset, afe_spi_clk, wr_ack}, 4'b1100);
    chk("restart state", {afe_tx_en, afe_rx_en, done, busy}, 4'b0001);
    n = 0;
    while (afe_reset && n < 50) begin n++; @(negedge clk); end
    chk("restart reset pulse", n, RST_CYCLES);
    wait_done("restart");
    chk_frame("aborted", 16'({a, d} >> 9), 7);
    chk_rom_frames("restart");
    wait_ack("after restart");
    host_check("after restart", a, d, rb_byte);

    // Restart and request in the same READY cycle: restart wins.
    a = 8'($urandom); d = 8'($urandom);
    wr_addr = a; wr_data = d; wr_req = 1'b1; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    chk("restart wins", {afe_reset, afe_sen, done}, 3'b110);
    wait_done("restart+req");
    chk_rom_frames("restart+req");
    wait_ack("restart+req");
    host_check("restart+req", a, d, rb_byte);

    chk("sclk half periods", sclk_viol, 0);
    chk("mosi stable while sclk high", mosi_viol, 0);
    chk("spi idle levels", idle_viol, 0);
    chk("regs0 no spi activity", dut0_viol, 0);
    chk("regs0 final state", {done0, tx0, rx0, wr_ack0, rd_data0, busy0}, {3'b111, 1'b0, 8'h00, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/afe_init_seq.md
AFE_INIT_SEQ -- requirements
Module: afe_init_seq

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per SPI clock half-period; legal range 1..255.
REQ-002 Parameter NUM_REGS, default 8: number of init table entries; legal range 0..64.
REQ-003 Parameter RST_CYCLES, default 64: clk cycles afe_reset is held high after reset release.
REQ-004 Parameter WAIT_CYCLES, default 256: clk cycles between afe_reset deassert and the first SPI frame.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. clk input 1: sole clock. reset_n input 1: async active-low reset.
REQ-006 restart  input  1: single-cycle pulse; re-runs the full init sequence.
REQ-007 wr_req  input  1: host SPI access request, held until wr_ack.
REQ-008 wr_addr  input  8: host register address; bit 7 = 1 marks a read.
REQ-009 wr_data  input  8: host write data.
REQ-010 wr_ack  output  1: single-cycle pulse at the end of the served frame.
REQ-011 rd_data  output  8: read data captured in the last read frame.
REQ-012 busy  output  1: high whenever not in READY, or while a frame is active.
REQ-013 done  output  1: high only in READY.
REQ-014 afe_reset, afe_sen, afe_spi_clk, afe_spi_mosi  output  1 each: AFE reset and SPI master pins.
REQ-015 afe_spi_miso  input  1: AFE SPI data out.
REQ-016 afe_tx_en, afe_rx_en  output  1 each: AFE path enables.

Function
REQ-017 States SHALL be RST_PULSE -> RST_WAIT -> LOAD -> SHIFT -> GAP -> (LOAD if entries remain, else ENABLE) -> READY; host frames run READY -> SHIFT -> GAP -> READY.
REQ-018 RST_PULSE SHALL drive afe_reset=1 for exactly RST_CYCLES clocks; RST_WAIT SHALL drive afe_reset=0 for WAIT_CYCLES clocks.
REQ-019 Each frame SHALL be 16 bits, MSB first ({addr, data}), with afe_sen low for the whole frame.
REQ-020 Bit timing: afe_spi_mosi SHALL be updated with afe_spi_clk low. afe_spi_clk SHALL be low for CLK_DIV clocks, then high for CLK_DIV clocks. afe_spi_miso SHALL be sampled on the clk where afe_spi_clk rises.
REQ-021 Frame length SHALL be 32*CLK_DIV clocks. GAP SHALL hold afe_sen=1 and afe_spi_clk=0 for CLK_DIV clocks.
REQ-022 LOAD SHALL fetch table entry idx. idx SHALL count 0..NUM_REGS-1 and reset to 0 on every init run.
REQ-023 With NUM_REGS=0, RST_WAIT SHALL go directly to ENABLE.
REQ-024 ENABLE SHALL last one clock, set afe_tx_en=afe_rx_en=1, then enter READY.
REQ-025 In READY, wr_req=1 SHALL start a frame on the next clock. wr_ack SHALL pulse on the last GAP clock.
REQ-026 wr_req during init or during an active frame SHALL stay pending, with no ack, until READY is idle.
REQ-027 restart SHALL be accepted in any state. It SHALL abort any frame (afe_sen=1 next clock), clear afe_tx_en/afe_rx_en and done, and enter RST_PULSE.
REQ-028 If restart and wr_req arrive in the same READY cycle, restart SHALL win and wr_req SHALL remain pending.
REQ-029 afe_spi_clk SHALL idle low and afe_spi_mosi SHALL idle 0 outside SHIFT.

Reset
REQ-030 When reset_n=0, outputs SHALL take these values: afe_reset=1, afe_sen=1, afe_spi_clk=0, afe_spi_mosi=0, afe_tx_en=0, afe_rx_en=0, busy=1, done=0, wr_ack=0, rd_data=0.
REQ-031 On reset_n release the block SHALL enter RST_PULSE; assertion mid-frame SHALL force afe_sen=1 asynchronously.

Configuration
REQ-032 Macro AFE_READBACK_EN, when defined: for frames with addr[7]=1, the 8 data-phase miso bits SHALL be shifted MSB first and loaded into rd_data on wr_ack.
REQ-033 Without AFE_READBACK_EN: afe_spi_miso SHALL be ignored and rd_data SHALL be constant 0; read frames are still clocked out.

Structure
REQ-034 Package afe_cfg_pkg SHALL hold the state enum, SPI_FRAME_BITS=16, the READ_BIT index (7), and the init-table entry type {addr[7:0], data[7:0]}.
REQ-035 Sub-module afe_cfg_rom SHALL be combinational, mapping idx to entry; the table contents live only there.

Verification
REQ-036 CLK_DIV=2, NUM_REGS=3, RST_CYCLES=4, WAIT_CYCLES=8; release reset -> afe_reset high 4 clks, three 64-clk frames carrying ROM entries 0,1,2 in order, then afe_tx_en=afe_rx_en=1 and done=1.
REQ-037 In READY, wr_req with addr=0x12, data=0xA5 -> MOSI stream 0x12A5 MSB first, wr_ack one pulse after 66 clks.
REQ-038 AFE_READBACK_EN defined; read addr=0x83, model returns 0x5C on miso -> rd_data=0x5C at wr_ack. Macro undefined -> rd_data=0.
REQ-039 wr_req asserted during init frame 1 -> no wr_ack until after ENABLE; host frame starts in the first READY cycle.
REQ-040 restart asserted at bit 7 of a host frame -> afe_sen=1 next clock, no wr_ack, enables drop, full init repeats, then the pending request is served.
REQ-041 NUM_REGS=0 -> no SPI activity; ENABLE follows RST_WAIT directly; done=1 after 4+8+1 clks.
